ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, 5000, c50 cycles the clock line is held low before a transmission (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, 750000, watchdog limit in c50 cycles between device clock falling edges (15 ms).
REQ-003 SHALL have parameter FILT_LEN, 16, length of the line-sample shift filter.
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports c50 and reset_all.
REQ-005 SHALL have port c50  input  1  system clock, 50 MHz.
REQ-006 SHALL have port reset_all  input  1  asynchronous active-low reset.
REQ-007 SHALL have port tx_valid  input  1  command byte offered.
REQ-008 SHALL have port tx_data  input  8  command byte (e.g. 8'hED set-LEDs).
REQ-009 SHALL have port tx_ready  output  1  block idle, byte accepted this cycle if tx_valid.
REQ-010 SHALL have port ps2_clk_in / ps2_dat_in  input  1 each  raw PS/2 line levels.
REQ-011 SHALL have port ps2_clk_oe / ps2_dat_oe  output  1 each  1 = drive line low; 0 = release (open collector).
REQ-012 SHALL have port tx_busy  output  1  transmission in progress; receiver ignores the lines while high.
REQ-013 SHALL have port tx_done / tx_error  output  1 each  one-cycle completion pulses (acked / nacked or timed out).

Function
REQ-014 SHALL filter both lines: FILT_LEN-deep shift of raw samples; output 1 when all ones, 0 when all zeros, else hold; filter reset value 1.
REQ-015 SHALL define a clock falling edge as filtered clk 1 on previous cycle and 0 on current cycle.
REQ-016 SHALL implement states IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE.
REQ-017 IDLE: tx_ready=1, both oe=0; on tx_valid&tx_ready latch tx_data and odd parity (~^tx_data), go INHIBIT next cycle.
REQ-018 INHIBIT: clk_oe=1 for exactly INHIBIT_CYC cycles; dat_oe rises on the final INHIBIT cycle; then RTS.
REQ-019 RTS: clk_oe=0, dat_oe=1 (start bit); on falling edge 1 present d0 and go SEND.
REQ-020 SEND: falling edges 2..8 present d1..d7 LSB first, edge 9 parity, edge 10 release data (stop bit); dat_oe = ~bit, updated the cycle after the edge; after edge 10 go ACK.
REQ-021 ACK: on falling edge 11 sample filtered data; 0 = ack, 1 = nack; go WAIT_IDLE.
REQ-022 WAIT_IDLE: when filtered clk and data both 1, pulse tx_done (ack) or tx_error (nack) one cycle and return IDLE.
REQ-023 Watchdog: counter cleared on entry to RTS and on each falling edge; reaching TIMEOUT_CYC in RTS/SEND/ACK/WAIT_IDLE releases both lines, pulses tx_error, returns IDLE.
REQ-024 tx_busy SHALL equal (state != IDLE); tx_ready SHALL equal (state == IDLE); tx_valid while busy is ignored and not queued.
REQ-025 tx_done and tx_error SHALL never assert in the same cycle; a completion pulse and a new acceptance may not coincide (acceptance earliest one cycle later).
REQ-026 Edge and bit counters SHALL be 4 bits; watchdog counter 20 bits, saturating-free (cleared before wrap).

Reset
REQ-027 reset_all low SHALL immediately force IDLE, clk_oe=0, dat_oe=0, tx_ready=1 once released, tx_busy/tx_done/tx_error=0, counters 0, filters 1, latched byte 0.
REQ-028 Reset mid-transmission SHALL release both lines within the same cycle (asynchronous), abandoning the frame without an error pulse.

Structure
REQ-029 Shared package ps2_pkg SHALL hold the state enum, default INHIBIT_CYC/TIMEOUT_CYC/FILT_LEN, and command constants 8'hED, 8'hF4, 8'hFF, 8'hFA (ack), 8'hFE (resend).
REQ-030 Line filter SHALL be sub-module ps2_line_filter, instanced twice, reusable by the receiver.

Verification
REQ-031 Send 8'hED with device model acking -> clk_oe low 5000 cycles, bits 1,0,1,1,0,1,1,1 then parity 1 observed at device rising edges, tx_done one pulse.
REQ-032 Send 8'h00 -> parity bit 1; send 8'h01 -> parity bit 0.
REQ-033 Device model leaves data high at edge 11 -> tx_error one pulse, no tx_done.
REQ-034 Device never clocks after RTS -> tx_error exactly 750000 cycles after RTS entry, both oe 0.
REQ-035 Assert reset_all low during bit 4 of 8'hF4 -> both oe 0 same cycle, IDLE, no pulses; next 8'hFF transmits normally.
REQ-036 Glitch of 10 cycles on ps2_clk_in during SEND -> no edge counted, byte delivered intact.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, timing defaults and the
// command/response bytes used by both the host transmitter and the receiver.
package ps2_pkg;

  localparam int INHIBIT_CYC_DEF = 5000;    // 100 us at 50 MHz
  localparam int TIMEOUT_CYC_DEF = 750000;  // 15 ms at 50 MHz
  localparam int FILT_LEN_DEF    = 16;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } state_e;

  // PS/2 frames carry odd parity over the data byte.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte handshake and status between a command source and the PS/2 host
// transmitter.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_busy, tx_done, tx_error
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Deglitcher for one raw PS/2 line: output only changes once FILT_LEN
// consecutive samples agree, otherwise it holds its last value.
module ps2_line_filter #(
  parameter int FILT_LEN = 16
) (
  input  logic c50,
  input  logic reset_all,
  input  logic raw_i,
  output logic filt_o
);

  logic [FILT_LEN-1:0] shift_q;
  logic                filt_q;

  always_ff @(posedge c50 or negedge reset_all) begin
    if (!reset_all) begin
      shift_q <= '1;
      filt_q  <= 1'b1;
    end else begin
      shift_q <= {shift_q[FILT_LEN-2:0], raw_i};
      if (&shift_q)
        filt_q <= 1'b1;
      else if (~|shift_q)
        filt_q <= 1'b0;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts out data/parity/stop on device clock falls and checks the line ack.
module ps2_host_tx import ps2_pkg::*; #(
  parameter int INHIBIT_CYC = INHIBIT_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic          c50,
  input  logic          reset_all,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe
);

  localparam int             CW       = $clog2(INHIBIT_CYC + 1);
  localparam logic [CW-1:0]  INH_LAST = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0]  INH_PRE  = CW'(INHIBIT_CYC - 2);
  localparam logic [19:0]    TO_CNT   = 20'(TIMEOUT_CYC);

  logic clk_f, dat_f, fall;
  logic clk_prev_q;

  state_e        state_q, state_d;
  logic [CW-1:0] inh_q, inh_d;
  logic [3:0]    edge_q, edge_d;
  logic [19:0]   wdog_q, wdog_d;
  logic [8:0]    sh_q, sh_d;
  logic          dat_oe_q, dat_oe_d;
  logic          nack_q, nack_d;
  logic          done, error, line_phase, timeout;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .c50(c50), .reset_all(reset_all), .raw_i(ps2_clk_in), .filt_o(clk_f)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .c50(c50), .reset_all(reset_all), .raw_i(ps2_dat_in), .filt_o(dat_f)
  );

  assign fall = clk_prev_q & ~clk_f;

  always_ff @(posedge c50 or negedge reset_all) begin
    if (!reset_all) begin
      state_q    <= ST_IDLE;
      inh_q      <= '0;
      edge_q     <= '0;
      wdog_q     <= '0;
      sh_q       <= '0;
      dat_oe_q   <= 1'b0;
      nack_q     <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      inh_q      <= inh_d;
      edge_q     <= edge_d;
      wdog_q     <= wdog_d;
      sh_q       <= sh_d;
      dat_oe_q   <= dat_oe_d;
      nack_q     <= nack_d;
      clk_prev_q <= clk_f;
    end
  end

  // Watchdog only runs while the device owns the clock; every fall restarts it.
  assign line_phase = (state_q == ST_RTS) || (state_q == ST_SEND) ||
                      (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
  assign timeout    = line_phase && (wdog_q == TO_CNT);

  always_comb begin
    state_d  = state_q;
    inh_d    = inh_q;
    edge_d   = edge_q;
    sh_d     = sh_q;
    dat_oe_d = dat_oe_q;
    nack_d   = nack_q;
    done     = 1'b0;
    error    = 1'b0;
    wdog_d   = line_phase ? (fall ? 20'd0 : wdog_q + 20'd1) : 20'd0;

    if (timeout) begin
      error    = 1'b1;
      dat_oe_d = 1'b0;
      edge_d   = '0;
      wdog_d   = '0;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.tx_valid) begin
            sh_d    = {odd_parity(bus.tx_data), bus.tx_data};
            inh_d   = '0;
            edge_d  = '0;
            nack_d  = 1'b0;
            state_d = ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          inh_d = inh_q + 1'b1;
          // Registered, so data goes low on the last inhibit cycle itself.
          if (inh_q == INH_PRE)
            dat_oe_d = 1'b1;
          if (inh_q == INH_LAST)
            state_d = ST_RTS;
        end
        ST_RTS: begin
          if (fall) begin
            dat_oe_d = ~sh_q[0];
            sh_d     = {1'b0, sh_q[8:1]};
            edge_d   = 4'd1;
            state_d  = ST_SEND;
          end
        end
        ST_SEND: begin
          if (fall) begin
            edge_d = edge_q + 4'd1;
            if (edge_q == 4'd9) begin
              dat_oe_d = 1'b0;
              state_d  = ST_ACK;
            end else begin
              dat_oe_d = ~sh_q[0];
              sh_d     = {1'b0, sh_q[8:1]};
            end
          end
        end
        ST_ACK: begin
          if (fall) begin
            edge_d  = edge_q + 4'd1;
            nack_d  = dat_f;
            state_d = ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_f && dat_f) begin
            done    = ~nack_q;
            error   = nack_q;
            edge_d  = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.tx_ready = (state_q == ST_IDLE);
  assign bus.tx_busy  = (state_q != ST_IDLE);
  assign bus.tx_done  = done;
  assign bus.tx_error = error;
  assign ps2_clk_oe   = (state_q == ST_INHIBIT);
  assign ps2_dat_oe   = dat_oe_q;

endmodule
